// File: rtl/poly_byte_encode.sv
// poly_byte_encode: streaming ML-KEM ByteEncode_D serializer.
// Packs one 256-coefficient polynomial into a little-endian bit stream of
// 256*D bits. It appends one coefficient per cycle into a bit accumulator and
// emits the stream as 64-bit words over a valid/ready interface.
//
// Ports:
//   clk_i    - clock
//   rst_n_i  - asynchronous active-low reset
//   run_i    - start pulse, sampled only in IDLE
//   poly_i   - polynomial; must stay stable while busy_o is high
//   data_o   - current output word
//   valid_o  - data_o holds a complete word
//   ready_i  - sink accepts the word (fire = valid_o && ready_i)
//   busy_o   - encode in progress
//   done_o   - one-cycle pulse after the final word fires
//
// Optional feature: define POLY_ENCODE_MODQ_EN to canonically reduce each
// coefficient mod q before it is truncated to D bits.

package poly_byte_encode_pkg;
  localparam int unsigned ML_KEM_Q     = 3329;
  localparam int unsigned ML_KEM_LEN_Q = 12;
  localparam int unsigned ML_KEM_N     = 256;

  typedef logic [ML_KEM_N-1:0][ML_KEM_LEN_Q-1:0] poly_t;
endpackage

module poly_byte_encode
  import poly_byte_encode_pkg::*;
#(
  parameter int unsigned D = 12
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        run_i,
  input  poly_t       poly_i,
  output logic [63:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned N_WORDS = 4 * D;
  localparam int unsigned ACC_W   = 64 + D - 1;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned IDX_W   = 9;
  localparam int unsigned WCNT_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                valid_d, busy_d, done_d;

  logic [ML_KEM_LEN_Q-1:0] coef_raw;
  logic [ML_KEM_LEN_Q-1:0] coef_red;
  logic [D-1:0]            coef_trunc;
  logic                    fire_c;

  // Coefficient selection and optional canonical reduction.
  assign coef_raw = poly_i[idx_q[7:0]];
`ifdef POLY_ENCODE_MODQ_EN
  assign coef_red = (coef_raw >= ML_KEM_LEN_Q'(ML_KEM_Q)) ?
                    (coef_raw - ML_KEM_LEN_Q'(ML_KEM_Q)) : coef_raw;
`else
  assign coef_red = coef_raw;
`endif
  assign coef_trunc = coef_red[D-1:0];

  assign fire_c = valid_o && ready_i;
  assign data_o = acc_q[63:0];

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      wcnt_q    <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      wcnt_q    <= wcnt_d;
      valid_o   <= valid_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
    end
  end

  // Next-state: start, append one coefficient, or shift out a fired word.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    wcnt_d    = wcnt_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (run_i) begin
          state_d   = RUN;
          idx_d     = '0;
          acc_d     = '0;
          acc_cnt_d = '0;
          wcnt_d    = '0;
        end
      end
      RUN: begin
        if (fire_c) begin
          // Residual bits (at most D-1) drop to the bottom of the accumulator.
          acc_d     = ACC_W'({64'd0, acc_q} >> 64);
          acc_cnt_d = acc_cnt_q - CNT_W'(64);
          if (wcnt_q == WCNT_W'(N_WORDS - 1)) begin
            state_d = IDLE;
            wcnt_d  = '0;
            done_d  = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end else if (acc_cnt_q < CNT_W'(64) && idx_q < IDX_W'(256)) begin
          acc_d     = acc_q | (ACC_W'(coef_trunc) << acc_cnt_q);
          acc_cnt_d = acc_cnt_q + CNT_W'(D);
          idx_d     = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs track the next-state values.
    busy_d  = (state_d == RUN);
    valid_d = (state_d == RUN) && (acc_cnt_d >= CNT_W'(64));
  end

endmodule

// File: tb/tb_poly_byte_encode.sv
// Bench for poly_byte_encode: D=12 and D=1 instances driven from one
// directed sequence, with words checked against a bit-stream model.
module tb_poly_byte_encode;
  import poly_byte_encode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run12, ready12, valid12, busy12, done12;
  logic        run1, ready1, valid1, busy1, done1;
  logic [63:0] data12, data1;
  poly_t       poly12, poly1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  poly_byte_encode #(.D(12)) dut12 (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run12), .poly_i(poly12),
    .data_o(data12), .valid_o(valid12), .ready_i(ready12),
    .busy_o(busy12), .done_o(done12)
  );

  poly_byte_encode #(.D(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run1), .poly_i(poly1),
    .data_o(data1), .valid_o(valid1), .ready_i(ready1),
    .busy_o(busy1), .done_o(done1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_coef(input logic [11:0] raw);
`ifdef POLY_ENCODE_MODQ_EN
    return (raw >= 12'd3329) ? raw - 12'd3329 : raw;
`else
    return raw;
`endif
  endfunction

  // Word w of the little-endian stream: stream bit j is bit (j % d) of coef j/d.
  function automatic logic [63:0] model_word(input poly_t p, input int d, input int w);
    logic [63:0] word;
    logic [11:0] c;
    int j;
    word = '0;
    for (int b = 0; b < 64; b++) begin
      j = 64 * w + b;
      c = model_coef(p[j / d]);
      word[b] = c[j % d];
    end
    return word;
  endfunction

  // Runs one encode on the selected instance. rmode 0: ready always high;
  // rmode 1: random ready with a 20-cycle low hold. rst_after >= 0 drops
  // reset once that many words have fired.
  task automatic encode(input int dsel, input int rmode, input int rst_after,
                        input string tag,
                        output logic [63:0] first_word, output logic [63:0] last_word);
    int d, nwords, k, n, first;
    logic v, b, dn, r, was_stall;
    logic [63:0] dat, held;
    poly_t p;
    d = dsel ? 1 : 12;
    nwords = 4 * d;
    p = dsel ? poly1 : poly12;
    k = 0; n = 0; first = -1; was_stall = 1'b0; held = '0;
    first_word = '0; last_word = '0;

    @(negedge clk);
    if (dsel) run1 = 1'b1; else run12 = 1'b1;
    @(negedge clk);
    run1 = 1'b0; run12 = 1'b0;

    while (k < nwords && n < 3000) begin
      v   = dsel ? valid1 : valid12;
      b   = dsel ? busy1  : busy12;
      dn  = dsel ? done1  : done12;
      dat = dsel ? data1  : data12;
      if (n == 0) check({tag, " busy_after_start"}, 64'(b), 64'd1);
      if (was_stall) begin
        check({tag, " valid_held"}, 64'(v), 64'd1);
        check({tag, " data_held"}, dat, held);
      end
      if (v) begin
        if (first < 0) begin
          first = n;
          check({tag, " first_valid_edge"}, 64'(first), 64'((64 + d - 1) / d));
        end
        check($sformatf("%s word%0d", tag, k), dat, model_word(p, d, k));
        if (k == 0) first_word = dat;
        if (k == nwords - 1) last_word = dat;
        held = dat;
      end
      if (rst_after >= 0 && k == rst_after) begin
        rst_n = 1'b0;
        #1;
        check({tag, " rst_valid"}, 64'(dsel ? valid1 : valid12), 64'd0);
        check({tag, " rst_busy"},  64'(dsel ? busy1  : busy12),  64'd0);
        check({tag, " rst_done"},  64'(dsel ? done1  : done12),  64'd0);
        #2;
        rst_n = 1'b1;
        ready1 = 1'b0; ready12 = 1'b0;
        @(negedge clk);
        check({tag, " post_rst_valid"}, 64'(dsel ? valid1 : valid12), 64'd0);
        check({tag, " post_rst_done"},  64'(dsel ? done1  : done12),  64'd0);
        return;
      end
      if (rmode == 0) r = 1'b1;
      else if (n >= 20 && n < 40) r = 1'b0;
      else r = 1'($urandom % 2);
      if (dsel) ready1 = r; else ready12 = r;
      was_stall = v && !r;
      if (v && r) k++;
      @(negedge clk);
      n++;
    end

    check({tag, " no_timeout"}, 64'(n < 3000), 64'd1);
    check({tag, " word_count"}, 64'(k), 64'(nwords));
    check({tag, " done_pulse"}, 64'(dsel ? done1 : done12), 64'd1);
    check({tag, " busy_fall"},  64'(dsel ? busy1 : busy12), 64'd0);
    check({tag, " valid_end"},  64'(dsel ? valid1 : valid12), 64'd0);
    ready1 = 1'b0; ready12 = 1'b0;
    @(negedge clk);
    check({tag, " done_once"}, 64'(dsel ? done1 : done12), 64'd0);
  endtask

  initial begin
    logic [63:0] fw, lw, fw_ref, lw_ref;
    rst_n = 1'b0;
    run12 = 1'b0; ready12 = 1'b0; run1 = 1'b0; ready1 = 1'b0;
    poly12 = '0; poly1 = '0;
    #1;
    check("reset valid12", 64'(valid12), 64'd0);
    check("reset busy12",  64'(busy12),  64'd0);
    check("reset done12",  64'(done12),  64'd0);
    check("reset data12",  data12,       64'd0);
    check("reset valid1",  64'(valid1),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All-zero polynomial.
    encode(0, 0, -1, "zero", fw, lw);
    check("zero last", lw, 64'd0);

    // Ramp poly_i[i] = i.
    for (int i = 0; i < 256; i++) poly12[i] = 12'(i);
    encode(0, 0, -1, "ramp", fw, lw);
    check("ramp word0_const", fw, 64'h5004003002001000);
    check("ramp last_top12", 64'(lw[63:52]), 64'h0FF);
    fw_ref = fw; lw_ref = lw;

    // Same ramp under random backpressure.
    encode(0, 1, -1, "ramp_stall", fw, lw);
    check("ramp_stall first", fw, fw_ref);
    check("ramp_stall last", lw, lw_ref);

    // Random in-range polynomial with backpressure.
    for (int i = 0; i < 256; i++) poly12[i] = 12'($urandom_range(0, 3328));
    encode(0, 1, -1, "rand", fw, lw);

    // D=1, all ones.
    for (int i = 0; i < 256; i++) poly1[i] = 12'd1;
    encode(1, 0, -1, "d1", fw, lw);
    check("d1 first_const", fw, 64'hFFFF_FFFF_FFFF_FFFF);
    check("d1 last_const", lw, 64'hFFFF_FFFF_FFFF_FFFF);

    // Coefficient equal to q.
    poly12 = '0;
    poly12[0] = 12'd3329;
    encode(0, 0, -1, "q", fw, lw);
`ifdef POLY_ENCODE_MODQ_EN
    check("q low12", 64'(fw[11:0]), 64'h000);
`else
    check("q low12", 64'(fw[11:0]), 64'hD01);
`endif

    // Reset after ten words, then a full clean encode.
    for (int i = 0; i < 256; i++) poly12[i] = 12'(i);
    encode(0, 0, 10, "rst_mid", fw, lw);
    encode(0, 0, -1, "after_rst", fw, lw);
    check("after_rst word0", fw, 64'h5004003002001000);
    check("after_rst last", lw, lw_ref);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
